prpg_engine: RTL and testbench

//  Parametrised PRPG execution engine: one W-bit Galois LFSR and one W-cell rule-based 1-D cellular automaton (CA).

---
 rtl/prpg_pkg.sv | 43 ++++
 rtl/prpg_step.sv | 30 +++
 rtl/prpg_engine.sv | 197 +++++++++++++++++++
 tb/tb_prpg_engine.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prpg_pkg.sv
// Shared opcode and FSM definitions for the PRPG engine.
// Optional Hamming-distance feature: PRPG_HAMMING_EN.
package prpg_pkg;

    typedef enum logic [5:0] {
        OP_HALT      = 6'd0,
        OP_CONFIG_L  = 6'd1,
        OP_INIT_L    = 6'd2,
        OP_RUN_L     = 6'd3,
        OP_INIT_ADDR = 6'd4,
        OP_ST_M_L    = 6'd5,
        OP_ADD_ADDR  = 6'd6,
        OP_LD_M_L    = 6'd7,
        OP_ST_M_HD   = 6'd8,
        OP_BATCH_L   = 6'd9,
        OP_CONFIG_C  = 6'd10,
        OP_INIT_C    = 6'd11,
        OP_RUN_C     = 6'd12,
        OP_ST_M_C    = 6'd13,
        OP_BATCH_C   = 6'd14,
        OP_LD_M_C    = 6'd15
    } prpg_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_BATCH = 2'd2,
        ST_HALT  = 2'd3
    } prpg_state_e;

    function automatic logic is_step_op(input logic [5:0] op);
        return (op == OP_RUN_L) || (op == OP_RUN_C) || (op == OP_BATCH_L) || (op == OP_BATCH_C);
    endfunction

    function automatic logic is_batch_op(input logic [5:0] op);
        return (op == OP_BATCH_L) || (op == OP_BATCH_C);
    endfunction

    function automatic logic is_ca_op(input logic [5:0] op);
        return (op == OP_RUN_C) || (op == OP_BATCH_C);
    endfunction

endpackage

// File: rtl/prpg_step.sv
// Combinational next-state for the Galois LFSR and the rule-based circular CA.
module prpg_step #(
    parameter int W = 8
) (
    input  logic [W-1:0] p,
    input  logic [W-2:0] tap,
    input  logic [W-1:0] q,
    input  logic [7:0]   rule,
    output logic [W-1:0] p_next,
    output logic [W-1:0] q_next
);

    // Galois LFSR: the top stage feeds stage 0 and is folded into every tapped stage.
    always_comb begin
        p_next    = '0;
        p_next[0] = p[W-1];
        for (int i = 1; i < W; i++) begin
            p_next[i] = tap[W-1-i] ? (p[W-1] ^ p[i-1]) : p[i-1];
        end
    end

    // CA cell looks up the rule bit indexed by {right, self, left} neighbours.
    always_comb begin
        q_next = '0;
        for (int i = 0; i < W; i++) begin
            q_next[i] = rule[{q[(i+1)%W], q[i], q[(i+W-1)%W]}];
        end
    end

endmodule

// File: rtl/prpg_engine.sv
// PRPG execution engine: LFSR + CA registers, pattern memory and instruction FSM.
// Optional macro PRPG_HAMMING_EN adds the hd port and the ST_M_HD store.
module prpg_engine
    import prpg_pkg::*;
#(
    parameter int W      = 8,
    parameter int ADDR_W = 8,
    parameter int IMM_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [5:0]        instr_op,
    input  logic [IMM_W-1:0]  instr_imm,
    output logic [W-1:0]      p_state,
    output logic [W-1:0]      q_state,
    output logic [ADDR_W-1:0] r_addr,
    output logic              busy,
    output logic              halted
`ifdef PRPG_HAMMING_EN
    ,
    output logic [$clog2(W+1)-1:0] hd
`endif
);

    prpg_state_e state_r;
    logic [W-2:0] tap_r;
    logic [7:0]   rule_r;
    logic [7:0]   cnt_r;
    logic [7:0]   n_r;
    logic         sel_ca_r;

    logic [W-1:0] p_next_s;
    logic [W-1:0] q_next_s;
    logic [W-1:0] mem_rdata_s;
    logic [W-1:0] mem_wdata_s;
    logic         mem_we_s;
    logic [7:0]   n_imm_s;
    logic         unused_imm_s;

    logic [W-1:0] mem_r [2**ADDR_W];

    assign n_imm_s      = instr_imm[7:0];
    assign unused_imm_s = ^instr_imm;
    assign mem_rdata_s  = mem_r[r_addr];
    assign instr_ready  = (state_r == ST_IDLE) && !rst;

    prpg_step #(.W(W)) u_step (
        .p      (p_state),
        .tap    (tap_r),
        .q      (q_state),
        .rule   (rule_r),
        .p_next (p_next_s),
        .q_next (q_next_s)
    );

`ifdef PRPG_HAMMING_EN
    localparam int HD_W = $clog2(W+1);
    assign hd = HD_W'($countones(p_state ^ p_next_s));
`endif

    // Memory write port: stores and every batch step write at the current r_addr.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_wdata_s = '0;
        case (state_r)
            ST_IDLE: begin
                if (instr_valid) begin
                    case (instr_op)
                        OP_ST_M_L: begin
                            mem_we_s    = 1'b1;
                            mem_wdata_s = p_state;
                        end
                        OP_ST_M_C: begin
                            mem_we_s    = 1'b1;
                            mem_wdata_s = q_state;
                        end
`ifdef PRPG_HAMMING_EN
                        OP_ST_M_HD: begin
                            mem_we_s    = 1'b1;
                            mem_wdata_s = W'(hd);
                        end
`endif
                        OP_BATCH_L: begin
                            mem_we_s    = (n_imm_s != 8'd0);
                            mem_wdata_s = p_next_s;
                        end
                        OP_BATCH_C: begin
                            mem_we_s    = (n_imm_s != 8'd0);
                            mem_wdata_s = q_next_s;
                        end
                        default: begin
                            mem_we_s    = 1'b0;
                            mem_wdata_s = '0;
                        end
                    endcase
                end else begin
                    mem_we_s = 1'b0;
                end
            end
            ST_BATCH: begin
                mem_we_s    = 1'b1;
                mem_wdata_s = sel_ca_r ? q_next_s : p_next_s;
            end
            default: begin
                mem_we_s    = 1'b0;
                mem_wdata_s = '0;
            end
        endcase
    end

    // Pattern memory has no reset; writes are suppressed while rst is high.
    always_ff @(posedge clk) begin
        if (mem_we_s && !rst) begin
            mem_r[r_addr] <= mem_wdata_s;
        end
    end

    // Instruction FSM and all architectural registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            p_state  <= '0;
            q_state  <= '0;
            tap_r    <= '0;
            rule_r   <= 8'd0;
            r_addr   <= '0;
            busy     <= 1'b0;
            halted   <= 1'b0;
            cnt_r    <= 8'd0;
            n_r      <= 8'd0;
            sel_ca_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (instr_valid) begin
                        case (instr_op)
                            OP_HALT: begin
                                state_r <= ST_HALT;
                                halted  <= 1'b1;
                            end
                            OP_CONFIG_L:  tap_r   <= instr_imm[W-2:0];
                            OP_INIT_L:    p_state <= instr_imm[W-1:0];
                            OP_CONFIG_C:  rule_r  <= instr_imm[7:0];
                            OP_INIT_C:    q_state <= instr_imm[W-1:0];
                            OP_INIT_ADDR: r_addr  <= instr_imm[ADDR_W-1:0];
                            OP_ADD_ADDR:  r_addr  <= r_addr + instr_imm[ADDR_W-1:0];
                            OP_LD_M_L:    p_state <= mem_rdata_s;
                            OP_LD_M_C:    q_state <= mem_rdata_s;
                            OP_RUN_L, OP_RUN_C, OP_BATCH_L, OP_BATCH_C: begin
                                // The accept edge performs step 1; only n > 1 needs the FSM.
                                if (n_imm_s != 8'd0) begin
                                    if (is_ca_op(instr_op)) begin
                                        q_state <= q_next_s;
                                    end else begin
                                        p_state <= p_next_s;
                                    end
                                    if (is_batch_op(instr_op)) begin
                                        r_addr <= r_addr + ADDR_W'(1'b1);
                                    end
                                    if (n_imm_s != 8'd1) begin
                                        state_r  <= is_batch_op(instr_op) ? ST_BATCH : ST_RUN;
                                        busy     <= 1'b1;
                                        cnt_r    <= 8'd1;
                                        n_r      <= n_imm_s;
                                        sel_ca_r <= is_ca_op(instr_op);
                                    end
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_RUN, ST_BATCH: begin
                    if (sel_ca_r) begin
                        q_state <= q_next_s;
                    end else begin
                        p_state <= p_next_s;
                    end
                    if (state_r == ST_BATCH) begin
                        r_addr <= r_addr + ADDR_W'(1'b1);
                    end
                    cnt_r <= cnt_r + 8'd1;
                    if ((cnt_r + 8'd1) == n_r) begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                        cnt_r   <= 8'd0;
                    end
                end
                ST_HALT: halted <= 1'b1;
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prpg_engine.sv
// Self-checking bench for prpg_engine (W=8, ADDR_W=8) against a behavioural model.
module tb_prpg_engine;

    localparam int W      = 8;
    localparam int ADDR_W = 8;
    localparam int IMM_W  = 8;
    localparam int MASK   = (1 << W) - 1;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              instr_valid = 1'b0;
    logic              instr_ready;
    logic [5:0]        instr_op = 6'd0;
    logic [IMM_W-1:0]  instr_imm = 8'd0;
    logic [W-1:0]      p_state;
    logic [W-1:0]      q_state;
    logic [ADDR_W-1:0] r_addr;
    logic              busy;
    logic              halted;
`ifdef PRPG_HAMMING_EN
    logic [$clog2(W+1)-1:0] hd;
`endif

    prpg_engine #(.W(W), .ADDR_W(ADDR_W), .IMM_W(IMM_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_imm   (instr_imm),
        .p_state     (p_state),
        .q_state     (q_state),
        .r_addr      (r_addr),
        .busy        (busy),
        .halted      (halted)
`ifdef PRPG_HAMMING_EN
        ,
        .hd          (hd)
`endif
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    // Behavioural model state
    int m_p, m_q, m_tap, m_rule, m_addr, m_halted;
    int m_mem [DEPTH];

    function automatic int lfsr_step(input int p, input int tap);
        int msb = (p >> (W-1)) & 1;
        int r = ((p << 1) & MASK) | msb;
        if (msb != 0)
            for (int i = 1; i < W; i++)
                if (((tap >> (W-1-i)) & 1) != 0) r ^= (1 << i);
        return r;
    endfunction

    function automatic int ca_step(input int q, input int rule);
        int r = 0;
        for (int i = 0; i < W; i++) begin
            int idx = ((q >> ((i+1)%W)) & 1) * 4 + ((q >> i) & 1) * 2 + ((q >> ((i+W-1)%W)) & 1);
            r |= ((rule >> idx) & 1) << i;
        end
        return r;
    endfunction

    function automatic int popcount(input int v);
        int c = 0;
        for (int i = 0; i < 32; i++) c += (v >> i) & 1;
        return c;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_p = 0; m_q = 0; m_tap = 0; m_rule = 0; m_addr = 0; m_halted = 0;
    endtask

    task automatic model_exec(input int op, input int imm);
        case (op)
            0:  m_halted = 1;
            1:  m_tap  = imm & ((1 << (W-1)) - 1);
            2:  m_p    = imm & MASK;
            4:  m_addr = imm % DEPTH;
            5:  m_mem[m_addr] = m_p;
            6:  m_addr = (m_addr + imm) % DEPTH;
            7:  m_p = m_mem[m_addr];
`ifdef PRPG_HAMMING_EN
            8:  m_mem[m_addr] = popcount(m_p ^ lfsr_step(m_p, m_tap));
`endif
            10: m_rule = imm & 255;
            11: m_q    = imm & MASK;
            13: m_mem[m_addr] = m_q;
            15: m_q = m_mem[m_addr];
            3, 9, 12, 14: begin
                for (int k = 0; k < (imm & 255); k++) begin
                    if (op == 3 || op == 9) m_p = lfsr_step(m_p, m_tap);
                    else                    m_q = ca_step(m_q, m_rule);
                    if (op == 9 || op == 14) begin
                        m_mem[m_addr] = (op == 9) ? m_p : m_q;
                        m_addr = (m_addr + 1) % DEPTH;
                    end
                end
            end
            default: ;
        endcase
    endtask

    task automatic check_all(input string tag);
        check({tag, ".p"}, p_state, m_p);
        check({tag, ".q"}, q_state, m_q);
        check({tag, ".addr"}, r_addr, m_addr);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".halted"}, halted, m_halted);
    endtask

    // Issue one instruction, wait for the engine to return to idle, compare with the model.
    task automatic issue(input int op, input int imm);
        int wait_c, low, exp_low;
        instr_op    = op[5:0];
        instr_imm   = imm[7:0];
        instr_valid = 1'b1;
        wait_c = 0;
        while (!instr_ready && wait_c < 20) begin
            @(negedge clk);
            wait_c++;
        end
        check("accept_ready", instr_ready, 1);
        @(posedge clk);
        #1 instr_valid = 1'b0;
        model_exec(op, imm);
        @(negedge clk);
        low = 0;
        while (!instr_ready && low < 300) begin
            low++;
            @(negedge clk);
        end
        exp_low = ((op == 3 || op == 9 || op == 12 || op == 14) && (imm & 255) > 1) ? (imm & 255) - 1 : 0;
        check($sformatf("ready_low op%0d", op), low, exp_low);
        check_all($sformatf("op%0d", op));
    endtask

    initial begin
        int exp_p, op, imm;
        logic [7:0] batch_exp [8];
        batch_exp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
        model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;

        // Reset state
        #1;
        check("rst.ready", instr_ready, 0);
        check_all("rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 check("post_rst.ready", instr_ready, 1);

        // Plain rotate: three steps in three cycles
        issue(1, 8'h00); issue(2, 8'h01); issue(3, 3);
        check("run3.p", p_state, 8'h08);

        // All taps set
        issue(1, 8'h7F); issue(2, 8'h80); issue(3, 1);
        check("run1_taps.p", p_state, 8'hFF);

        // CA rule 0x14
        issue(10, 8'h14); issue(11, 8'h10); issue(12, 1);
        check("ca.q", q_state, 8'h18);

        // Batch across the address wrap, then read each entry back
        issue(1, 8'h00); issue(2, 8'h01); issue(4, 250); issue(9, 8);
        check("batch.addr", r_addr, 2);
        issue(4, 250);
        for (int k = 0; k < 8; k++) begin
            issue(15, 0);
            check($sformatf("batch.mem%0d", k), q_state, batch_exp[k]);
            issue(6, 1);
        end

`ifdef PRPG_HAMMING_EN
        issue(1, 8'h00); issue(2, 8'h01);
        check("hd", hd, 2);
        issue(8, 0); issue(15, 0);
        check("st_hd.q", q_state, 8'h02);
`endif

        // Fill the whole memory so random loads have known contents
        issue(1, 8'h1D); issue(2, 8'hA5); issue(4, 0); issue(9, 255); issue(9, 1);
        check("fill.addr", r_addr, 0);

        // Random instruction stream
        for (int it = 0; it < 60; it++) begin
            op = $urandom_range(1, 20);
            if (op > 15) op = $urandom_range(16, 63);
            if (op == 3 || op == 9 || op == 12 || op == 14) imm = $urandom_range(0, 12);
            else                                            imm = $urandom_range(0, 255);
            issue(op, imm);
        end

        // Reset in the middle of a long RUN
        issue(1, 8'h2B); issue(2, 8'h3C);
        exp_p = m_p;
        for (int k = 0; k < 50; k++) exp_p = lfsr_step(exp_p, m_tap);
        instr_op = 6'd3; instr_imm = 8'd200; instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        repeat (49) @(posedge clk);
        #1;
        check("run50.p", p_state, exp_p);
        check("run50.busy", busy, 1);
        check("run50.ready", instr_ready, 0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("midrst");
        check("midrst.ready", instr_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("midrst_rel.ready", instr_ready, 1);
        @(negedge clk);
        issue(7, 0);

        // HALT is terminal
        instr_op = 6'd0; instr_imm = 8'd0; instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        model_exec(0, 0);
        @(negedge clk);
        check("halt.halted", halted, 1);
        check("halt.ready", instr_ready, 0);
        instr_op = 6'd2; instr_imm = 8'h55; instr_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("halt_blk.p", p_state, m_p);
        check("halt_blk.halted", halted, 1);
        check("halt_blk.ready", instr_ready, 0);
        instr_valid = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
